// File: rtl/tx_req_arbiter_if.sv
// rtl/tx_req_arbiter_if.sv - requester and TX FIFO write bus bundle for tx_req_arbiter
interface tx_req_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IdW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid_i;
  logic [8*NUM_REQ-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_last_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic                 tx_fifo_full_i;
  logic                 tx_fifo_wen_o;
  logic [7:0]           tx_fifo_wdata_o;
  logic [NUM_REQ-1:0]   grant_o;
  logic [IdW-1:0]       grant_id_o;
  logic                 arb_busy_o;

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, tx_fifo_full_i,
    output req_ready_o, tx_fifo_wen_o, tx_fifo_wdata_o, grant_o, grant_id_o, arb_busy_o
  );

  modport master (
    output req_valid_i, req_data_i, req_last_i, tx_fifo_full_i,
    input  req_ready_o, tx_fifo_wen_o, tx_fifo_wdata_o, grant_o, grant_id_o, arb_busy_o
  );
endinterface

// File: rtl/tx_req_arbiter.sv
// rtl/tx_req_arbiter.sv - round-robin burst-locking arbiter for the TX FIFO write port
module tx_req_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             arb_en_i,
  tx_req_arbiter_if.slave  bus
);
  localparam int IdW   = $clog2(NUM_REQ);
  localparam int BeatW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]   grant_id_q, grant_id_d;
  logic [BeatW-1:0] beat_q, beat_d;

  logic             sel_found;
  logic [IdW-1:0]   sel_idx;
  logic [IdW:0]     probe;
  logic [IdW:0]     next_ptr;
  logic             fire;

  // First valid requester at or after rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    probe     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      probe = {1'b0, rr_ptr_q} + (IdW+1)'(i);
      if (probe >= (IdW+1)'(NUM_REQ)) begin
        probe = probe - (IdW+1)'(NUM_REQ);
      end
      if (!sel_found && bus.req_valid_i[probe[IdW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = probe[IdW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_d     = beat_q;
    fire       = 1'b0;
    next_ptr   = {1'b0, grant_id_q} + 1'b1;
    if (next_ptr == (IdW+1)'(NUM_REQ)) begin
      next_ptr = '0;
    end

    bus.req_ready_o     = '0;
    bus.tx_fifo_wen_o   = 1'b0;
    bus.tx_fifo_wdata_o = '0;
    bus.grant_o         = '0;
    bus.grant_id_o      = grant_id_q;
    bus.arb_busy_o      = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_en_i && sel_found) begin
          state_d    = GRANT;
          grant_id_d = sel_idx;
          beat_d     = '0;
        end
      end
      GRANT: begin
        bus.arb_busy_o              = 1'b1;
        bus.grant_o[grant_id_q]     = 1'b1;
        bus.req_ready_o[grant_id_q] = arb_en_i & ~bus.tx_fifo_full_i;
        fire = bus.req_valid_i[grant_id_q] & arb_en_i & ~bus.tx_fifo_full_i;
        if (fire) begin
          bus.tx_fifo_wen_o   = 1'b1;
          bus.tx_fifo_wdata_o = bus.req_data_i[{grant_id_q, 3'b000} +: 8];
          beat_d              = beat_q + 1'b1;
          // Message end or burst cap hands the port to the next requester.
          if (bus.req_last_i[grant_id_q] || beat_d == BeatW'(MAX_BURST)) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr[IdW-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_q     <= beat_d;
    end
  end
endmodule
